// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared 64-bit mtime, per-hart mtimecmp/msip,
// exposed as a single address-decoded register slave with a one-cycle busy handshake.
module clint_mh #(
    parameter int NHARTS   = 2,
    parameter int PRESCALE = 1,
    parameter int ADDR_W   = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ren,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              addr_err,
    output logic [NHARTS-1:0] timer_int,
    output logic [NHARTS-1:0] soft_int
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE_S = 1'b0,
        RESP_S = 1'b1
    } state_t;

    state_t            state_r;
    logic [63:0]       mtime_r;
    logic [PW-1:0]     presc_r;
    logic [63:0]       mtimecmp_r [NHARTS];
    logic [NHARTS-1:0] msip_r;
    logic [NHARTS-1:0] timer_int_r;
    logic [31:0]       rdata_r;
    logic              addr_err_r;

    logic [31:0]       addr_s;
    logic [HW-1:0]     hart_s;
    logic              sel_msip_s;
    logic              sel_cmp_s;
    logic              sel_mtime_s;
    logic              hi_s;
    logic              hit_s;
    logic [31:0]       rd_val_s;
    logic              do_acc_s;
    logic              do_wr_s;
    logic              tick_s;

    assign addr_s   = 32'(addr);
    assign do_acc_s = (state_r == IDLE_S) && (ren || wen);
    assign do_wr_s  = do_acc_s && wen;
    assign tick_s   = (presc_r == PRESC_MAX);
    assign hit_s    = sel_msip_s || sel_cmp_s || sel_mtime_s;

    // Address decode: region select, hart index and word half
    always_comb begin
        sel_msip_s  = 1'b0;
        sel_cmp_s   = 1'b0;
        sel_mtime_s = 1'b0;
        hi_s        = 1'b0;
        hart_s      = '0;
        if (addr_s[1:0] != 2'b00) begin
            sel_msip_s = 1'b0;
        end else if (addr_s < 32'(4 * NHARTS)) begin
            sel_msip_s = 1'b1;
            hart_s     = addr_s[2 +: HW];
        end else if ((addr_s >= 32'h0000_4000) && (addr_s < (32'h0000_4000 + 32'(8 * NHARTS)))) begin
            sel_cmp_s = 1'b1;
            hart_s    = addr_s[3 +: HW];
            hi_s      = addr_s[2];
        end else if ((addr_s == 32'h0000_BFF8) || (addr_s == 32'h0000_BFFC)) begin
            sel_mtime_s = 1'b1;
            hi_s        = addr_s[2];
        end else begin
            sel_mtime_s = 1'b0;
        end
    end

    // Read data mux over the currently held register values
    always_comb begin
        rd_val_s = 32'h0000_0000;
        if (sel_msip_s) begin
            rd_val_s = {31'h0000_0000, msip_r[hart_s]};
        end else if (sel_cmp_s) begin
            rd_val_s = hi_s ? mtimecmp_r[hart_s][63:32] : mtimecmp_r[hart_s][31:0];
        end else if (sel_mtime_s) begin
            rd_val_s = hi_s ? mtime_r[63:32] : mtime_r[31:0];
        end else begin
            rd_val_s = 32'h0000_0000;
        end
    end

    // Prescaler and mtime; a bus write to mtime wins over the increment and restarts the count
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mtime_r <= 64'h0;
            presc_r <= '0;
        end else if (do_wr_s && sel_mtime_s) begin
            presc_r <= '0;
            if (hi_s) begin
                mtime_r[63:32] <= wdata;
            end else begin
                mtime_r[31:0] <= wdata;
            end
        end else if (tick_s) begin
            mtime_r <= mtime_r + 64'd1;
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Per-hart mtimecmp and msip registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int h = 0; h < NHARTS; h++) begin
                mtimecmp_r[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
            end
            msip_r <= '0;
        end else if (do_wr_s && sel_cmp_s) begin
            if (hi_s) begin
                mtimecmp_r[hart_s][63:32] <= wdata;
            end else begin
                mtimecmp_r[hart_s][31:0] <= wdata;
            end
        end else if (do_wr_s && sel_msip_s) begin
            msip_r[hart_s] <= wdata[0];
        end else begin
            msip_r <= msip_r;
        end
    end

    // Timer interrupt follows the unsigned compare of the current register values
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            timer_int_r <= '0;
        end else begin
            for (int h = 0; h < NHARTS; h++) begin
                timer_int_r[h] <= (mtime_r >= mtimecmp_r[h]);
            end
        end
    end

    // Handshake FSM: access at the IDLE edge, response held for one RESP cycle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r    <= IDLE_S;
            rdata_r    <= 32'h0000_0000;
            addr_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE_S: begin
                    if (ren || wen) begin
                        state_r    <= RESP_S;
                        rdata_r    <= wen ? 32'h0000_0000 : rd_val_s;
                        addr_err_r <= !hit_s;
                    end else begin
                        addr_err_r <= 1'b0;
                    end
                end
                RESP_S: begin
                    state_r    <= IDLE_S;
                    addr_err_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE_S;
                    addr_err_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = do_acc_s;
    assign rdata     = rdata_r;
    assign addr_err  = addr_err_r;
    assign timer_int = timer_int_r;
    assign soft_int  = msip_r;

endmodule

// File: tb/tb_clint_mh.sv
// Bench for clint_mh: two instances (PRESCALE 1 and 4) on one shared bus, checked each
// cycle against a time-based model, plus directed transactions with literal expectations.
module tb_clint_mh;

    localparam int NH = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [31:0] wdata = 32'h0;

    logic [31:0]   rdata1, rdata4;
    logic          busy1, busy4, err1, err4;
    logic [NH-1:0] tint1, tint4, sint1, sint4;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    clint_mh #(.NHARTS(NH), .PRESCALE(1), .ADDR_W(16)) dut1 (
        .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .busy(busy1), .addr_err(err1), .timer_int(tint1), .soft_int(sint1)
    );

    clint_mh #(.NHARTS(NH), .PRESCALE(4), .ADDR_W(16)) dut4 (
        .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata4), .busy(busy4), .addr_err(err4), .timer_int(tint4), .soft_int(sint4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // mtime of instance k in cycle c is base_val + (c - base_cyc) / P, re-anchored on writes/reset.
    longint unsigned cyc = 0;
    longint unsigned base_cyc [2];
    logic [63:0]     base_val [2];
    int              presc_of [2] = '{1, 4};
    logic [63:0]     cmp [NH];
    logic [NH-1:0]   msip = '0;
    bit              resp = 1'b0;
    logic [31:0]     exp_rd [2];
    bit              exp_err = 1'b0;
    logic [NH-1:0]   exp_tint [2];

    function automatic logic [63:0] mt(input int k, input longint unsigned c);
        return base_val[k] + 64'((c - base_cyc[k]) / longint'(presc_of[k]));
    endfunction

    function automatic void dec(input logic [15:0] a, output int kind, output int h, output bit hi);
        int ai;
        ai = int'(a);
        kind = 0; h = 0; hi = 1'b0;
        if (ai % 4 != 0) kind = 0;
        else if (ai < 4 * NH) begin kind = 1; h = ai / 4; end
        else if (ai >= 'h4000 && ai < 'h4000 + 8 * NH) begin
            kind = 2; h = (ai - 'h4000) / 8; hi = ((ai - 'h4000) % 8) == 4;
        end
        else if (ai == 'hBFF8) kind = 3;
        else if (ai == 'hBFFC) begin kind = 3; hi = 1'b1; end
    endfunction

    task automatic model_step();
        int kind, h;
        bit hi;
        logic [63:0] v;
        if (!nRST) begin
            for (int k = 0; k < 2; k++) begin
                base_cyc[k] = cyc + 1;
                base_val[k] = 64'h0;
                exp_tint[k] = '0;
                exp_rd[k]   = 32'h0;
            end
            for (int i = 0; i < NH; i++) cmp[i] = 64'hFFFF_FFFF_FFFF_FFFF;
            msip = '0; resp = 1'b0; exp_err = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < NH; i++) exp_tint[k][i] = (mt(k, cyc) >= cmp[i]);
            if (!resp && (ren || wen)) begin
                dec(addr, kind, h, hi);
                exp_err = (kind == 0);
                for (int k = 0; k < 2; k++) exp_rd[k] = 32'h0;
                if (wen) begin
                    if (kind == 1) msip[h] = wdata[0];
                    else if (kind == 2) begin
                        if (hi) cmp[h][63:32] = wdata; else cmp[h][31:0] = wdata;
                    end else if (kind == 3) begin
                        for (int k = 0; k < 2; k++) begin
                            v = mt(k, cyc);
                            if (hi) v[63:32] = wdata; else v[31:0] = wdata;
                            base_val[k] = v;
                            base_cyc[k] = cyc + 1;
                        end
                    end
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        v = mt(k, cyc);
                        if (kind == 1) exp_rd[k] = {31'h0, msip[h]};
                        else if (kind == 2) exp_rd[k] = hi ? cmp[h][63:32] : cmp[h][31:0];
                        else if (kind == 3) exp_rd[k] = hi ? v[63:32] : v[31:0];
                    end
                end
                resp = 1'b1;
            end else begin
                resp = 1'b0;
                exp_err = 1'b0;
            end
        end
        cyc++;
    endtask

    // Model advance on each edge and full output compare just after it
    initial begin
        forever begin
            @(posedge CLK);
            model_step();
            #1;
            chk("busy1", 64'(busy1), 64'(!resp && (ren || wen)));
            chk("busy4", 64'(busy4), 64'(!resp && (ren || wen)));
            chk("addr_err1", 64'(err1), 64'(exp_err));
            chk("addr_err4", 64'(err4), 64'(exp_err));
            chk("timer_int1", 64'(tint1), 64'(exp_tint[0]));
            chk("timer_int4", 64'(tint4), 64'(exp_tint[1]));
            chk("soft_int1", 64'(sint1), 64'(msip));
            chk("soft_int4", 64'(sint4), 64'(msip));
            if (resp) begin
                chk("rdata1", 64'(rdata1), 64'(exp_rd[0]));
                chk("rdata4", 64'(rdata4), 64'(exp_rd[1]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Starts on a falling edge with the slave idle; ends two cycles later, idle again.
    task automatic xact(input bit r, input bit w, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] r1, output logic [31:0] r4, output logic e);
        ren = r; wen = w; addr = a; wdata = d;
        #1 chk("busy_on_request", 64'(busy1), 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        chk("busy_in_resp", 64'(busy1), 64'd0);
        r1 = rdata1; r4 = rdata4; e = err1;
        ren = 1'b0; wen = 1'b0;
        @(negedge CLK);
    endtask

    logic [31:0] r1, r4, a1, a2;
    logic        e;
    int          n;

    initial begin
        nRST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_rdata", 64'(rdata1), 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_err", 64'(err1), 64'd0);
        chk("rst_tint", 64'(tint1), 64'd0);
        chk("rst_sint", 64'(sint1), 64'd0);
        nRST = 1'b1;
        @(negedge CLK);

        // mtime counts up; back-to-back reads are 2 cycles apart
        xact(1'b1, 1'b0, 16'hBFF8, 32'h0, a1, r4, e);
        xact(1'b1, 1'b0, 16'hBFF8, 32'h0, a2, r4, e);
        chk("mtime_first_read", 64'(a1), 64'd1);
        chk("mtime_second_read", 64'(a2), 64'd3);
        xact(1'b1, 1'b0, 16'h4000, 32'h0, r1, r4, e);
        chk("mtimecmp0_lo_reset", 64'(r1), 64'hFFFF_FFFF);
        xact(1'b1, 1'b0, 16'h4004, 32'h0, r1, r4, e);
        chk("mtimecmp0_hi_reset", 64'(r1), 64'hFFFF_FFFF);

        // Timer for hart 1 at 0x20
        xact(1'b0, 1'b1, 16'h400C, 32'h0, r1, r4, e);
        xact(1'b0, 1'b1, 16'h4008, 32'h20, r1, r4, e);
        chk("tint_before_match", 64'(tint1), 64'd0);
        n = 0;
        while (!tint1[1] && n < 64) begin
            @(negedge CLK);
            n++;
        end
        chk("tint_rise", 64'(tint1), 64'b10);
        xact(1'b1, 1'b0, 16'hBFF8, 32'h0, r1, r4, e);
        chk("mtime_at_tint_rise", 64'(r1), 64'h21);

        // Software interrupt, only bit0 matters
        xact(1'b0, 1'b1, 16'h0004, 32'h1, r1, r4, e);
        chk("sint_set", 64'(sint1), 64'b10);
        xact(1'b1, 1'b0, 16'h0004, 32'h0, r1, r4, e);
        chk("msip1_read", 64'(r1), 64'd1);
        xact(1'b0, 1'b1, 16'h0004, 32'hFFFF_FFFE, r1, r4, e);
        chk("sint_clear", 64'(sint1), 64'b00);

        // mtime wrap
        xact(1'b0, 1'b1, 16'hBFFC, 32'hFFFF_FFFF, r1, r4, e);
        xact(1'b0, 1'b1, 16'hBFF8, 32'hFFFF_FFFF, r1, r4, e);
        xact(1'b1, 1'b0, 16'hBFFC, 32'h0, r1, r4, e);
        chk("wrap_hi_p1", 64'(r1), 64'd0);
        chk("wrap_hi_p4", 64'(r4), 64'hFFFF_FFFF);
        xact(1'b1, 1'b0, 16'hBFF8, 32'h0, r1, r4, e);
        chk("wrap_lo_p1", 64'(r1), 64'd2);
        chk("wrap_lo_p4", 64'(r4), 64'hFFFF_FFFF);

        // Prescaler restart after an mtime write
        xact(1'b0, 1'b1, 16'hBFF8, 32'h100, r1, r4, e);
        xact(1'b1, 1'b0, 16'hBFF8, 32'h0, r1, r4, e);
        chk("presc_rd0_p1", 64'(r1), 64'h101);
        chk("presc_rd0_p4", 64'(r4), 64'h100);
        xact(1'b1, 1'b0, 16'hBFF8, 32'h0, r1, r4, e);
        chk("presc_rd1_p1", 64'(r1), 64'h103);
        chk("presc_rd1_p4", 64'(r4), 64'h100);
        xact(1'b1, 1'b0, 16'hBFF8, 32'h0, r1, r4, e);
        chk("presc_rd2_p1", 64'(r1), 64'h105);
        chk("presc_rd2_p4", 64'(r4), 64'h101);

        // Unmapped, misaligned, and ren+wen together
        xact(1'b1, 1'b0, 16'h0008, 32'h0, r1, r4, e);
        chk("hart2_rdata", 64'(r1), 64'd0);
        chk("hart2_err", 64'(e), 64'd1);
        xact(1'b1, 1'b0, 16'h4004, 32'h0, r1, r4, e);
        xact(1'b1, 1'b0, 16'h0002, 32'h0, r1, r4, e);
        chk("misaligned_rdata", 64'(r1), 64'd0);
        chk("misaligned_err", 64'(e), 64'd1);
        xact(1'b1, 1'b0, 16'h4004, 32'h0, r1, r4, e);
        chk("cmp0_hi_before_rw", 64'(r1), 64'hFFFF_FFFF);
        xact(1'b1, 1'b1, 16'h4000, 32'h1234, r1, r4, e);
        chk("rw_rdata", 64'(r1), 64'd0);
        chk("rw_err", 64'(e), 64'd0);
        xact(1'b1, 1'b0, 16'h4000, 32'h0, r1, r4, e);
        chk("rw_written", 64'(r1), 64'h1234);

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
